// File: rtl/pipe_stage_reg.sv
// Purpose: reusable valid/ready pipeline-stage register with optional 2-entry skid buffer,
//          branch flush, global pause, occupancy report and saturating flush-drop counter.
// Latency: 1 cycle from up_fire to dn_valid_out; 1 transfer/cycle sustained.
// Backpressure: SKID_EN=1 -> up_ready_out from state + rdy_in only; SKID_EN=0 -> passes dn_ready_in through.
//
// Ports:
//   clk_in, rst_in (sync, active-low)   rdy_in  (global enable)   flush_in (kill all held entries)
//   up_valid_in / up_data_in / up_ready_out     upstream handshake
//   dn_valid_out / dn_data_out / dn_ready_in    downstream handshake (data is 0 when not valid)
//   occupancy_out (0..2)   drop_cnt_out (entries killed by flush, saturating at 255)
module pipe_stage_reg #(
  parameter int DATA_W  = 128,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              up_valid_in,
  input  logic [DATA_W-1:0] up_data_in,
  output logic              up_ready_out,
  output logic              dn_valid_out,
  output logic [DATA_W-1:0] dn_data_out,
  input  logic              dn_ready_in,
  output logic [1:0]        occupancy_out,
  output logic [7:0]        drop_cnt_out
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_dat, main_nxt;
  logic [DATA_W-1:0] skid_dat, skid_nxt;
  logic [7:0]        drop_cnt, drop_nxt;
  logic [8:0]        drop_sum;
  logic              main_vld;
  logic              up_fire;
  logic              dn_fire;

  assign main_vld = (state != EMPTY);

  // Reset gating keeps ready low while the block is held in reset. With the skid
  // buffer the only other combinational input is rdy_in; without it the downstream
  // ready is passed straight through so a full MAIN can be replaced in one cycle.
  assign up_ready_out = rst_in & rdy_in &
                        (SKID_EN ? (state != FULL) : (!main_vld | dn_ready_in));

  assign up_fire = up_valid_in & up_ready_out;
  assign dn_fire = main_vld & dn_ready_in & rdy_in;

  assign dn_valid_out  = main_vld;
  assign dn_data_out   = main_dat;
  assign occupancy_out = state;
  assign drop_cnt_out  = drop_cnt;

  // A flush kills everything held plus anything captured in the same cycle.
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, occupancy_out} + {8'd0, up_fire};

  always_comb begin
    state_nxt = state;
    main_nxt  = main_dat;
    skid_nxt  = skid_dat;
    drop_nxt  = drop_cnt;
    if (flush_in) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
      drop_nxt  = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end else if (rdy_in) begin
      unique case (state)
        EMPTY: begin
          if (up_fire) begin
            state_nxt = ONE;
            main_nxt  = up_data_in;
          end
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            main_nxt = up_data_in;
          end else if (up_fire && SKID_EN) begin
            // Downstream stalled: park the newcomer behind MAIN.
            state_nxt = FULL;
            skid_nxt  = up_data_in;
          end else if (dn_fire) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
          end
        end
        FULL: begin
          if (dn_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_dat;
            skid_nxt  = '0;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= EMPTY;
      main_dat <= '0;
      skid_dat <= '0;
      drop_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      main_dat <= main_nxt;
      skid_dat <= skid_nxt;
      drop_cnt <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, rdy, flush;
  logic         uv, dr, urdy, dv;
  logic [W-1:0] ud, dd;
  logic [1:0]   occ;
  logic [7:0]   drop;
  logic         uv0, dr0, urdy0, dv0;
  logic [W-1:0] ud0, dd0;
  logic [1:0]   occ0;
  logic [7:0]   drop0;

  int tests = 0;
  int fails = 0;
  int exp_drop = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .SKID_EN(1'b1)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .up_valid_in(uv), .up_data_in(ud), .up_ready_out(urdy),
    .dn_valid_out(dv), .dn_data_out(dd), .dn_ready_in(dr),
    .occupancy_out(occ), .drop_cnt_out(drop)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID_EN(1'b0)) dut0 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .up_valid_in(uv0), .up_data_in(ud0), .up_ready_out(urdy0),
    .dn_valid_out(dv0), .dn_data_out(dd0), .dn_ready_in(dr0),
    .occupancy_out(occ0), .drop_cnt_out(drop0)
  );

  // Advance one cycle. At the falling edge the handshakes of the skid instance are
  // observed: accepted payloads are queued, delivered payloads are checked in order.
  task automatic tick;
    logic [W-1:0] e;
    @(negedge clk);
    if (!rst || flush) begin
      sb.delete();
    end else if (rdy) begin
      if (dv && dr) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL sb_underflow: delivered %h, expected nothing", dd);
        end else begin
          e = sb.pop_front();
          if (dd !== e) begin fails++; $display("FAIL sb_order: delivered %h, expected %h", dd, e); end
        end
      end
      if (uv && urdy) sb.push_back(ud);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; uv = 1'b1; ud = 16'h1234; dr = 1'b1;
    uv0 = 1'b0; ud0 = '0; dr0 = 1'b1;
    tick; tick;
    tests++; if (urdy !== 1'b0) begin fails++; $display("FAIL rst_urdy: got %b want 0", urdy); end
    tests++; if (dv !== 1'b0 || dd !== 16'h0) begin fails++; $display("FAIL rst_dn: got %b/%h want 0/0", dv, dd); end
    tests++; if (occ !== 2'd0 || drop !== 8'd0) begin fails++; $display("FAIL rst_cnt: got occ %0d drop %0d want 0/0", occ, drop); end
    rst = 1'b1; uv = 1'b0;
    #1;
    tests++; if (urdy !== 1'b1) begin fails++; $display("FAIL rst_release_urdy: got %b want 1", urdy); end
    exp_drop = 0;
  endtask

  task automatic test_streaming;
    for (int i = 1; i <= 8; i++) begin
      uv = 1'b1; ud = W'(i); dr = 1'b1;
      tick;
      tests++; if (dv !== 1'b1 || dd !== W'(i)) begin fails++; $display("FAIL stream_out[%0d]: got %b/%h want 1/%h", i, dv, dd, W'(i)); end
      tests++; if (occ > 2'd1 || urdy !== 1'b1) begin fails++; $display("FAIL stream_flow[%0d]: occ %0d urdy %b want <=1/1", i, occ, urdy); end
    end
    uv = 1'b0;
    tick;
    tests++; if (dv !== 1'b0 || occ !== 2'd0) begin fails++; $display("FAIL stream_drain: dv %b occ %0d want 0/0", dv, occ); end
  endtask

  task automatic test_backpressure;
    uv = 1'b1; ud = 16'h000A; dr = 1'b1;
    tick;
    ud = 16'h000B; dr = 1'b0;
    tick;
    uv = 1'b0;
    #1;
    tests++; if (occ !== 2'd2 || urdy !== 1'b0) begin fails++; $display("FAIL bp_full: occ %0d urdy %b want 2/0", occ, urdy); end
    tests++; if (dd !== 16'h000A) begin fails++; $display("FAIL bp_head: got %h want 000a", dd); end
    dr = 1'b1;
    tick;
    tests++; if (dd !== 16'h000B || occ !== 2'd1 || urdy !== 1'b1) begin fails++; $display("FAIL bp_release: dd %h occ %0d urdy %b want 000b/1/1", dd, occ, urdy); end
    tick;
    tests++; if (dv !== 1'b0 || occ !== 2'd0) begin fails++; $display("FAIL bp_drain: dv %b occ %0d want 0/0", dv, occ); end
  endtask

  task automatic test_flush;
    // ONE under backpressure, flush together with a new capture: 1 held + 1 incoming.
    uv = 1'b1; ud = 16'h00C1; dr = 1'b1;
    tick;
    flush = 1'b1; ud = 16'h00C2; dr = 1'b0;
    tick;
    flush = 1'b0; uv = 1'b0;
    exp_drop += 2;
    tests++; if (drop !== 8'(exp_drop)) begin fails++; $display("FAIL flush_one_drop: got %0d want %0d", drop, exp_drop); end
    tests++; if (dv !== 1'b0 || dd !== 16'h0 || occ !== 2'd0) begin fails++; $display("FAIL flush_one_clear: dv %b dd %h occ %0d want 0/0/0", dv, dd, occ); end
    tests++; if (urdy !== 1'b1) begin fails++; $display("FAIL flush_one_urdy: got %b want 1", urdy); end
    // From FULL: both entries dropped, upstream is not ready so no capture.
    uv = 1'b1; ud = 16'h00D1; dr = 1'b0;
    tick;
    ud = 16'h00D2;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0; uv = 1'b0; dr = 1'b1;
    exp_drop += 2;
    tests++; if (drop !== 8'(exp_drop)) begin fails++; $display("FAIL flush_full_drop: got %0d want %0d", drop, exp_drop); end
    tests++; if (dv !== 1'b0 || dd !== 16'h0 || occ !== 2'd0) begin fails++; $display("FAIL flush_full_clear: dv %b dd %h occ %0d want 0/0/0", dv, dd, occ); end
  endtask

  task automatic test_pause;
    uv = 1'b1; ud = 16'h0020; dr = 1'b1;
    tick;
    rdy = 1'b0; ud = 16'h0021;
    #1;
    tests++; if (urdy !== 1'b0) begin fails++; $display("FAIL pause_urdy: got %b want 0", urdy); end
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++; if (dv !== 1'b1 || dd !== 16'h0020 || occ !== 2'd1) begin fails++; $display("FAIL pause_hold[%0d]: dv %b dd %h occ %0d want 1/0020/1", i, dv, dd, occ); end
    end
    rdy = 1'b1;
    tick;
    tests++; if (dd !== 16'h0021) begin fails++; $display("FAIL pause_resume: got %h want 0021", dd); end
    ud = 16'h0022;
    tick;
    tests++; if (dd !== 16'h0022) begin fails++; $display("FAIL pause_next: got %h want 0022", dd); end
    uv = 1'b0;
    tick;
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 300; k++) begin
      uv = 1'b1; ud = k[15:0]; dr = 1'b0;
      tick;
      uv = 1'b0; flush = 1'b1;
      tick;
      flush = 1'b0;
      exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
      if (k == 99) begin
        tests++; if (drop !== 8'(exp_drop)) begin fails++; $display("FAIL sat_mid: got %0d want %0d", drop, exp_drop); end
      end
    end
    tests++; if (drop !== 8'd255) begin fails++; $display("FAIL sat_final: got %0d want 255", drop); end
    dr = 1'b1;
  endtask

  task automatic test_reset_full;
    uv = 1'b1; ud = 16'h00E1; dr = 1'b0;
    tick;
    ud = 16'h00E2;
    tick;
    uv = 1'b0;
    tests++; if (occ !== 2'd2) begin fails++; $display("FAIL rstf_pre: occ %0d want 2", occ); end
    // Reset outranks a simultaneous flush; the cleared entries are not counted.
    rst = 1'b0; flush = 1'b1;
    tick;
    tests++; if (dv !== 1'b0 || dd !== 16'h0 || occ !== 2'd0 || drop !== 8'd0 || urdy !== 1'b0) begin
      fails++; $display("FAIL rstf_clear: dv %b dd %h occ %0d drop %0d urdy %b want all 0", dv, dd, occ, drop, urdy);
    end
    rst = 1'b1; flush = 1'b0; dr = 1'b1;
    #1;
    tests++; if (urdy !== 1'b1) begin fails++; $display("FAIL rstf_urdy: got %b want 1", urdy); end
    exp_drop = 0;
  endtask

  task automatic test_noskid;
    uv0 = 1'b1; ud0 = 16'h0055; dr0 = 1'b1;
    tick;
    tests++; if (dv0 !== 1'b1 || dd0 !== 16'h0055) begin fails++; $display("FAIL ns_first: dv %b dd %h want 1/0055", dv0, dd0); end
    dr0 = 1'b0; ud0 = 16'h0056;
    #1;
    tests++; if (urdy0 !== 1'b0) begin fails++; $display("FAIL ns_stall_urdy: got %b want 0", urdy0); end
    tick;
    tests++; if (dd0 !== 16'h0055 || occ0 !== 2'd1) begin fails++; $display("FAIL ns_stall_hold: dd %h occ %0d want 0055/1", dd0, occ0); end
    dr0 = 1'b1;
    #1;
    tests++; if (urdy0 !== 1'b1) begin fails++; $display("FAIL ns_urdy: got %b want 1", urdy0); end
    for (int i = 0; i < 4; i++) begin
      ud0 = W'(16'h0056 + i);
      tick;
      tests++; if (dd0 !== W'(16'h0056 + i) || occ0 !== 2'd1) begin fails++; $display("FAIL ns_replace[%0d]: dd %h occ %0d want %h/1", i, dd0, occ0, W'(16'h0056 + i)); end
    end
    uv0 = 1'b0;
    tick;
    tests++; if (dv0 !== 1'b0 || dd0 !== 16'h0 || drop0 !== 8'd0) begin fails++; $display("FAIL ns_drain: dv %b dd %h drop %0d want 0/0/0", dv0, dd0, drop0); end
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_backpressure;
    test_flush;
    test_pause;
    test_saturation;
    test_reset_full;
    test_noskid;
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: %0d entries never delivered, want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
